// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block/round constants, controller state type and
// the combinational round primitives used by aes_round_step.
package aes_pkg;

    localparam int BLOCK_W    = 128;
    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [7:0] rnd);
        case (rnd)
            8'd1:    return 8'h01;
            8'd2:    return 8'h02;
            8'd3:    return 8'h04;
            8'd4:    return 8'h08;
            8'd5:    return 8'h10;
            8'd6:    return 8'h20;
            8'd7:    return 8'h40;
            8'd8:    return 8'h80;
            8'd9:    return 8'h1b;
            8'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Derives round key rnd from round key rnd-1.
    function automatic logic [127:0] expandkey(input logic [127:0] k, input logic [7:0] rnd);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rcon(rnd), 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte i of the block sits at [8*(15-i) +: 8]; byte r+4c is row r, column c.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(r+4*c)) +: 8] = sbox(s[8*(15-(r+4*((c+r)%4))) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt_round(input logic [127:0] s, input logic [127:0] rk);
        return mix_columns(sub_shift(s)) ^ rk;
    endfunction

    function automatic logic [127:0] encrypt_round10(input logic [127:0] s, input logic [127:0] rk);
        return sub_shift(s) ^ rk;
    endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES-128 round: expands the next round key and applies it; the final
// round (rnd==10) skips MixColumns.
module aes_round_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic [3:0]         rnd,
    output logic [BLOCK_W-1:0] next_state,
    output logic [BLOCK_W-1:0] next_key
);

    logic [BLOCK_W-1:0] key_next;

    assign key_next   = expandkey(round_key, {4'd0, rnd});
    assign next_key   = key_next;
    assign next_state = (rnd == 4'(NUM_ROUNDS)) ? encrypt_round10(state, key_next)
                                                : encrypt_round(state, key_next);

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: accepts one block, runs 10 rounds at
// ROUNDS_PER_CYCLE rounds per clock, holds the result until taken.
// Optional abort input enabled by AES_ITER_ABORT_EN.
module aes_iter_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] plain_text,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] cipher_text,
    output logic               busy
`ifdef AES_ITER_ABORT_EN
    ,
    input  logic               abort
`endif
);

    localparam int R = ROUNDS_PER_CYCLE;

    fsm_state_t         fsm_reg;
    logic [BLOCK_W-1:0] state_reg;
    logic [BLOCK_W-1:0] key_reg;
    logic [BLOCK_W-1:0] cipher_reg;
    logic [3:0]         rnd_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               busy_reg;

    logic [R:0][BLOCK_W-1:0] chain_state;
    logic [R:0][BLOCK_W-1:0] chain_key;
    logic [R-1:0][3:0]       chain_rnd;
    logic                    last_step;
    logic                    abort_hit;

    assign chain_state[0] = state_reg;
    assign chain_key[0]   = key_reg;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_step
            assign chain_rnd[gi] = rnd_reg + 4'(gi);
            aes_round_step u_step (
                .state      (chain_state[gi]),
                .round_key  (chain_key[gi]),
                .rnd        (chain_rnd[gi]),
                .next_state (chain_state[gi+1]),
                .next_key   (chain_key[gi+1])
            );
        end
    endgenerate

    assign last_step = (chain_rnd[R-1] == 4'(NUM_ROUNDS));

`ifdef AES_ITER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            key_reg       <= '0;
            cipher_reg    <= '0;
            rnd_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= plain_text ^ key;
                        key_reg      <= key;
                        rnd_reg      <= 4'd1;
                        fsm_reg      <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        fsm_reg      <= IDLE;
                        rnd_reg      <= '0;
                        in_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end else begin
                        state_reg <= chain_state[R];
                        key_reg   <= chain_key[R];
                        if (last_step) begin
                            fsm_reg       <= DONE;
                            cipher_reg    <= chain_state[R];
                            out_valid_reg <= 1'b1;
                            rnd_reg       <= '0;
                        end else begin
                            rnd_reg <= rnd_reg + 4'(R);
                        end
                    end
                end
                DONE: begin
                    // abort discards the result just as a take would release it
                    if (abort_hit || out_ready) begin
                        fsm_reg       <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    fsm_reg       <= IDLE;
                    rnd_reg       <= '0;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign busy        = busy_reg;
    assign cipher_text = cipher_reg;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Self-checking bench for aes_iter_ctrl: transaction-level AES-128 model
// (S-box derived from GF(2^8) arithmetic) checked every cycle, plus FIPS-197 vectors.
module tb_aes_iter_ctrl;

    parameter int RPC = 1;
    localparam int LAT = 10 / RPC;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key = '0;
    logic [127:0] plain_text = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] cipher_text;
    logic         busy;
`ifdef AES_ITER_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    aes_iter_ctrl #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .key         (key),
        .plain_text  (plain_text),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .busy        (busy)
`ifdef AES_ITER_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: bound expired, required event not seen", name);
    endtask

    // ---------------- reference AES-128 ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a  = a << 1;
            if (hi) a ^= 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc, s [16], u [16], a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 16; j++) s[j] = p[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    u[row+4*c] = sb[s[row+4*((c+row)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (r < 10) begin
                    u[4*c]   = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
                    u[4*c+1] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
                    u[4*c+2] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
                    u[4*c+3] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = u[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) o[127-8*j -: 8] = s[j];
        return o;
    endfunction

    // ---------------- transaction-level model ----------------
    // A block is held from its accept edge until taken; it becomes visible
    // once LAT edges have passed since the accept.
    bit           m_have = 1'b0;
    int           m_age = 0;
    logic [127:0] m_exp = '0;
    bit           m_ct_zero = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have    <= 1'b0;
            m_age     <= 0;
            m_ct_zero <= 1'b1;
        end else if (m_have) begin
            if ((m_age >= LAT && out_ready)
`ifdef AES_ITER_ABORT_EN
                || abort
`endif
               ) m_have <= 1'b0;
            else m_age <= m_age + 1;
        end else if (in_valid) begin
            m_have    <= 1'b1;
            m_age     <= 0;
            m_exp     <= aes_ref(key, plain_text);
            m_ct_zero <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("in_ready", 128'(in_ready), 128'(!m_have));
        check("busy", 128'(busy), 128'(m_have));
        check("out_valid", 128'(out_valid), 128'(m_have && m_age >= LAT));
        if (m_have && m_age >= LAT) check("cipher_text", cipher_text, m_exp);
        else if (m_ct_zero) check("cipher_text_reset", cipher_text, '0);
    end

    logic [127:0] got_q [$];
    always @(posedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(cipher_text);

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] k, input logic [127:0] p);
        bit ok = 1'b0;
        key = k; plain_text = p; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!in_ready) begin ok = 1'b1; break; end
        end
        in_valid = 1'b0;
        if (!ok) note_fail("accept");
    endtask

    // Returns cycles from the accept edge until out_valid; scrambles inputs meanwhile.
    task automatic wait_ov(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin n = i; break; end
            in_valid = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom, $urandom, $urandom};
            plain_text = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        if (n < 0) note_fail("out_valid");
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int n;

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
        end
        check("model_vec1", aes_ref(K1, P1), C1);
        check("model_vec2", aes_ref(K2, P2), C2);

        repeat (3) @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Vector 1, latency, inputs scrambled during RUN
        send(K1, P1);
        wait_ov(n);
        $display("vec1: latency %0d cycles, cipher %h", n, cipher_text);
        check("latency_vec1", 128'(n), 128'(LAT));
        check("vec1_cipher", cipher_text, C1);
        take();

        // Vector 2, result held 20 cycles while out_ready low
        send(K2, P2);
        wait_ov(n);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_cipher", cipher_text, C2);
            check("hold_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        $display("vec2: held cipher %h", cipher_text);
        take();

        // Back-to-back with in_valid held high
        got_q.delete();
        out_ready = 1'b1;
        key = K1; plain_text = P1; in_valid = 1'b1;
        for (int i = 0; i < 40 && in_ready; i++) @(negedge clk);
        key = K2; plain_text = P2;
        for (int i = 0; i < 60 && got_q.size() < 2; i++) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (got_q.size() < 2) note_fail("b2b_results");
        else begin
            $display("b2b: %h then %h", got_q[0], got_q[1]);
            check("b2b_first", got_q[0], C1);
            check("b2b_second", got_q[1], C2);
        end
        @(negedge clk);

        // Reset in the 4th RUN cycle
        send(K1, P1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_cipher", cipher_text, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        send(K2, P2);
        wait_ov(n);
        $display("post-reset: cipher %h", cipher_text);
        check("post_reset_cipher", cipher_text, C2);
        take();

`ifdef AES_ITER_ABORT_EN
        send(K1, P1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_busy", 128'(busy), 128'(0));
        repeat (LAT + 2) @(negedge clk);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        check("abort_idle_ready", 128'(in_ready), 128'(1));
        send(K2, P2);
        wait_ov(n);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_done_ov", 128'(out_valid), 128'(0));
        $display("abort: run, idle and done aborts applied");
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) == 0);
            key        = {$urandom, $urandom, $urandom, $urandom};
            plain_text = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_ITER_ABORT_EN
            abort      = ($urandom_range(0, 19) == 0);
`endif
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
`ifdef AES_ITER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (LAT + 4) @(negedge clk);
        $display("random: %0d results taken in total", got_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 SHALL have parameter: ROUNDS_PER_CYCLE, default 1, AES rounds applied per clock; legal values 1 or 2.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  key/plain_text valid.
REQ-005 SHALL have port: in_ready  output  1  block can be accepted.
REQ-006 SHALL have port: key  input  128  cipher key, sampled on accept.
REQ-007 SHALL have port: plain_text  input  128  plaintext, sampled on accept.
REQ-008 SHALL have port: out_valid  output  1  cipher_text valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes cipher_text.
REQ-010 SHALL have port: cipher_text  output  128  result, held stable while out_valid=1.
REQ-011 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE: in_ready=1; accept occurs when in_valid=1 and in_ready=1 at a clock edge.
REQ-014 On accept: state_reg <= plain_text XOR key, key_reg <= key, rnd <= 1, go to RUN.
REQ-015 In RUN, per cycle, for each of ROUNDS_PER_CYCLE chained steps:
- key_next = expandkey(key_reg, rnd as 8-bit round index 1..10)
- state = full round (rnd<10) or final round without MixColumns (rnd=10) using key_next
- rnd increments per step.
REQ-016 When round 10 completes: go to DONE, cipher_text <= final state, out_valid=1.
REQ-017 Latency: out_valid rises 10/ROUNDS_PER_CYCLE cycles after the accept edge (10 or 5).
REQ-018 In DONE: out_valid=1, in_ready=0; on out_ready=1, go to IDLE.
REQ-019 out_valid SHALL be held until taken; cipher_text, out_valid SHALL not change while out_ready=0.
REQ-020 in_valid during RUN/DONE SHALL be ignored; no input sampling outside IDLE.
REQ-021 out_ready=1 with new in_valid=1 in DONE: output taken, IDLE next cycle; new block accepted no earlier than the following edge (throughput 1 block per 12 or 7 cycles).
REQ-022 rnd SHALL be 4 bits; values 11..15 unreachable; any illegal FSM encoding SHALL return to IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE; in_ready=1 after reset, out_valid=0, busy=0, cipher_text=0, rnd=0, state_reg=0, key_reg=0.
REQ-024 Reset during RUN or DONE SHALL discard the block; no out_valid follows.

Configuration
REQ-025 Macro AES_ITER_ABORT_EN SHALL add input abort (1 bit).
- Defined: abort=1 at an edge in RUN or DONE returns to IDLE, out_valid=0, block discarded.
- In IDLE, abort SHALL have no effect; abort beats out_ready in DONE.
- Undefined: no abort port; behaviour as REQ-012..022.

Structure
REQ-026 Package aes_pkg SHALL hold BLOCK_W=128, NUM_ROUNDS=10, and the FSM state enum typedef.
REQ-027 SHALL use one sub-module aes_round_step: inputs state, round key, rnd; outputs next state, next key.
- Wraps expandkey plus encrypt_round/encrypt_round10, selected by rnd==10.
- Instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-028 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept (5 with ROUNDS_PER_CYCLE=2).
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; hold out_ready=0 for 20 cycles -> output stable, in_ready=0 throughout.
REQ-030 Back-to-back blocks, in_valid held high -> second accept on first edge in IDLE after output taken; both results correct.
REQ-031 rst_n low at RUN cycle 4 -> outputs at reset values immediately; no out_valid; next block result correct.
REQ-032 With AES_ITER_ABORT_EN: abort at RUN cycle 3 -> IDLE next cycle, out_valid never asserted; abort in IDLE -> no state change.
REQ-033 Change key/plain_text inputs during RUN -> result still matches the values sampled at accept.
